// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin merge of NSRC result streams into a 2-entry
// output queue feeding the single commit port.
module wb_arbiter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned TAGW = 8,
    parameter int unsigned NSRC = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       flush_i,
    input  logic [NSRC-1:0]            src_valid_i,
    input  logic [NSRC*XLEN-1:0]       src_data_i,
    input  logic [NSRC*TAGW-1:0]       src_itag_i,
    output logic [NSRC-1:0]            src_ready_o,
    output logic                       wb_valid_o,
    output logic [XLEN-1:0]            wb_data_o,
    output logic [TAGW-1:0]            wb_itag_o,
    output logic [$clog2(NSRC)-1:0]    wb_src_o,
    input  logic                       wb_ready_i
);

    localparam int unsigned SW = $clog2(NSRC);

    logic [XLEN-1:0] data_q [2];
    logic [TAGW-1:0] itag_q [2];
    logic [SW-1:0]   src_q  [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic [SW-1:0]   rr_ptr_q;

    logic [SW-1:0]   gnt_idx;
    logic            gnt_found;
    logic [SW-1:0]   rr_next;
    logic            push;
    logic            pop;

    // Search ascends from rr_ptr_q, wrapping modulo NSRC.
    always_comb begin
        logic [SW-1:0] idx;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            idx = SW'((32'(rr_ptr_q) + i) % NSRC);
            if (!gnt_found && src_valid_i[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        src_ready_o = '0;
        if (gnt_found && (count_q != 2'd2) && !flush_i) begin
            src_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign push    = |(src_valid_i & src_ready_o);
    assign pop     = wb_valid_o & wb_ready_i;
    assign rr_next = SW'((32'(gnt_idx) + 32'd1) % NSRC);

    assign wb_valid_o = (count_q != 2'd0);
    assign wb_data_o  = data_q[rd_ptr_q];
    assign wb_itag_o  = itag_q[rd_ptr_q];
    assign wb_src_o   = src_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                itag_q[i] <= '0;
                src_q[i]  <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            rr_ptr_q <= '0;
        end else if (flush_i) begin
            // Storage keeps its contents; count 0 is what invalidates entries.
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            rr_ptr_q <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= src_data_i[gnt_idx*XLEN +: XLEN];
                itag_q[wr_ptr_q] <= src_itag_i[gnt_idx*TAGW +: TAGW];
                src_q[wr_ptr_q]  <= gnt_idx;
                wr_ptr_q         <= ~wr_ptr_q;
                rr_ptr_q         <= rr_next;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: constant per-cycle vectors plus a reference model with
// a scoreboard queue of expected head entries.
module tb_wb_arbiter;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TAGW = 8;
    localparam int unsigned NSRC = 4;

    logic                  clk_i = 1'b0;
    logic                  arst_i = 1'b0;
    logic                  flush_i = 1'b0;
    logic [NSRC-1:0]       src_valid_i = '0;
    logic [NSRC*XLEN-1:0]  src_data_i = '0;
    logic [NSRC*TAGW-1:0]  src_itag_i = '0;
    logic [NSRC-1:0]       src_ready_o;
    logic                  wb_valid_o;
    logic [XLEN-1:0]       wb_data_o;
    logic [TAGW-1:0]       wb_itag_o;
    logic [1:0]            wb_src_o;
    logic                  wb_ready_i = 1'b0;

    wb_arbiter #(.XLEN(XLEN), .TAGW(TAGW), .NSRC(NSRC)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .flush_i     (flush_i),
        .src_valid_i (src_valid_i),
        .src_data_i  (src_data_i),
        .src_itag_i  (src_itag_i),
        .src_ready_o (src_ready_o),
        .wb_valid_o  (wb_valid_o),
        .wb_data_o   (wb_data_o),
        .wb_itag_o   (wb_itag_o),
        .wb_src_o    (wb_src_o),
        .wb_ready_i  (wb_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       wbr;
        logic       flush;
        logic [3:0] exp_ready;
        logic       exp_wbv;
        logic [1:0] exp_src;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [TAGW-1:0] itag;
        logic [1:0]      src;
    } entry_t;

    entry_t          exp_q[$];
    vec_t            tbl[$];
    int              m_rr;
    logic [XLEN-1:0] pdata [NSRC];
    logic [TAGW-1:0] ptag  [NSRC];
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_payload();
        for (int k = 0; k < NSRC; k++) begin
            src_data_i[k*XLEN +: XLEN] = pdata[k];
            src_itag_i[k*TAGW +: TAGW] = ptag[k];
        end
    endtask

    // Asynchronous pulse placed mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk_i);
        src_valid_i = '0;
        flush_i     = 1'b0;
        #2 arst_i = 1'b1;
        #1;
        check({tag, " rst wb_valid"}, 64'(wb_valid_o), 64'd0);
        check({tag, " rst wb_data"}, wb_data_o, 64'd0);
        check({tag, " rst wb_itag"}, 64'(wb_itag_o), 64'd0);
        check({tag, " rst wb_src"}, 64'(wb_src_o), 64'd0);
        check({tag, " rst src_ready"}, 64'(src_ready_o), 64'd0);
        #1 arst_i = 1'b0;
        exp_q.delete();
        m_rr = 0;
    endtask

    task automatic step(input string tag, input vec_t v, input logic chk_const);
        logic [3:0] m_ready;
        int         g;
        @(negedge clk_i);
        src_valid_i = v.valid;
        wb_ready_i  = v.wbr;
        flush_i     = v.flush;
        drive_payload();
        #1;
        g = -1;
        for (int i = 0; i < NSRC; i++) begin
            if (g < 0 && v.valid[(m_rr + i) % NSRC]) g = (m_rr + i) % NSRC;
        end
        m_ready = (g >= 0 && exp_q.size() < 2 && !v.flush) ? 4'(1 << g) : 4'b0;
        check({tag, " model src_ready"}, 64'(src_ready_o), 64'(m_ready));
        check({tag, " model wb_valid"}, 64'(wb_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check({tag, " head data"}, wb_data_o, exp_q[0].data);
            check({tag, " head itag"}, 64'(wb_itag_o), 64'(exp_q[0].itag));
            check({tag, " head src"}, 64'(wb_src_o), 64'(exp_q[0].src));
        end
        if (chk_const) begin
            check({tag, " vec src_ready"}, 64'(src_ready_o), 64'(v.exp_ready));
            check({tag, " vec wb_valid"}, 64'(wb_valid_o), 64'(v.exp_wbv));
            if (v.exp_wbv) check({tag, " vec wb_src"}, 64'(wb_src_o), 64'(v.exp_src));
        end
        @(posedge clk_i);
        if (v.flush) begin
            exp_q.delete();
            m_rr = 0;
        end else begin
            if (exp_q.size() != 0 && v.wbr) void'(exp_q.pop_front());
            if (m_ready != 0) begin
                exp_q.push_back('{data: pdata[g], itag: ptag[g], src: 2'(g)});
                m_rr = (g + 1) % NSRC;
                pdata[g] = pdata[g] + 64'h100;
                ptag[g]  = ptag[g] + 8'h10;
            end
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic wbr,
                                input logic flush, input logic [3:0] er, input logic ewbv,
                                input logic [1:0] esrc);
        vec_t v;
        v.rst = rst; v.valid = valid; v.wbr = wbr; v.flush = flush;
        v.exp_ready = er; v.exp_wbv = ewbv; v.exp_src = esrc;
        return v;
    endfunction

    initial begin
        pdata[0] = 64'h0A0A; pdata[1] = 64'h1111; pdata[2] = 64'h2222; pdata[3] = 64'h3333;
        for (int k = 0; k < NSRC; k++) ptag[k] = 8'(k + 4);

        // Single source, free-flowing
        tbl.push_back(mk(1, 4'b0010, 1, 0, 4'b0010, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0));
        // All four valid from reset
        tbl.push_back(mk(1, 4'b1111, 1, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0100, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b1000, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0001, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0));
        // Back-pressure, sources 0 and 2
        tbl.push_back(mk(1, 4'b0101, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 0, 0, 4'b0100, 1, 0));
        tbl.push_back(mk(0, 4'b0101, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0001, 1, 2));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0));
        // Pointer wrap: bring rr_ptr to 3, then 0 and 3 valid
        tbl.push_back(mk(1, 4'b0100, 1, 0, 4'b0100, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 4'b1000, 1, 2));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 4'b0001, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0));
        // Flush with count==2, pop presented in flush cycle
        tbl.push_back(mk(1, 4'b0011, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 0, 0, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0110, 0, 0, 4'b0010, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset($sformatf("v%0d", i));
            step($sformatf("v%0d", i), tbl[i], 1'b1);
        end

        // Reset pulse while the queue holds two entries
        do_reset("mid0");
        step("mid1", mk(0, 4'b1111, 0, 0, 4'b0001, 0, 0), 1'b1);
        step("mid2", mk(0, 4'b1111, 0, 0, 4'b0010, 1, 0), 1'b1);
        do_reset("mid3");
        step("mid4", mk(0, 4'b1111, 1, 0, 4'b0001, 0, 0), 1'b1);
        step("mid5", mk(0, 4'b0000, 1, 0, 4'b0000, 1, 0), 1'b1);
        step("mid6", mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0), 1'b1);

        // Random traffic checked against the model only
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i),
                 mk(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 40) == 0), 4'b0, 0, 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
